// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and widths for the elastic inter-stage registers.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // ID/EX control bundle; later boundaries carry a subset of these fields.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [2:0] alu_control;
        logic       alu_src;
        logic       reg_dst;
    } ctrl_t;

    localparam int IF_ID_CTRL_W  = 1;
    localparam int ID_EX_CTRL_W  = $bits(ctrl_t);
    localparam int EX_MEM_CTRL_W = 3;
    localparam int MEM_WB_CTRL_W = 2;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg_entry.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_entry_reg
//  Description : One valid+data+ctrl holding register with load/clear/flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_entry_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Data is left stale on clear/flush; ctrl is always zeroed with valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule : pipe_entry_reg
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Elastic pipeline stage register with flush and optional skid.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [OCC_W-1:0]  occupancy
);

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_load;
    logic              w_main_clear;
    logic [DATA_W-1:0] w_main_data;
    logic [CTRL_W-1:0] w_main_ctrl;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_data),
        .i_ctrl  (w_main_ctrl),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_ctrl  (out_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            occ_state_t        r_state;
            logic              r_in_ready;
            logic              w_skid_load;
            logic              w_skid_clear;
            logic              w_skid_valid;
            logic [DATA_W-1:0] w_skid_data;
            logic [CTRL_W-1:0] w_skid_ctrl;
            logic              w_drain_skid;

            // In FULL the head refills from the skid entry, never from input.
            assign w_drain_skid = (r_state == OCC_FULL) & w_out_fire;
            assign w_main_load  = w_drain_skid
                                | ((r_state == OCC_EMPTY) & w_in_fire)
                                | ((r_state == OCC_ONE) & w_in_fire & w_out_fire);
            assign w_main_clear = (r_state == OCC_ONE) & w_out_fire & ~w_in_fire;
            assign w_main_data  = (r_state == OCC_FULL) ? w_skid_data : in_data;
            assign w_main_ctrl  = (r_state == OCC_FULL) ? w_skid_ctrl : in_ctrl;
            assign w_skid_load  = (r_state == OCC_ONE) & w_in_fire & ~w_out_fire;
            assign w_skid_clear = w_drain_skid;

            pipe_entry_reg #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk     (clk),
                .rst     (rst),
                .i_flush (flush),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_data  (in_data),
                .i_ctrl  (in_ctrl),
                .o_valid (w_skid_valid),
                .o_data  (w_skid_data),
                .o_ctrl  (w_skid_ctrl)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state    <= OCC_EMPTY;
                    r_in_ready <= 1'b1;
                end else if (flush) begin
                    r_state    <= OCC_EMPTY;
                    r_in_ready <= 1'b1;
                end else begin
                    case (r_state)
                        OCC_EMPTY: begin
                            if (w_in_fire) begin
                                r_state <= OCC_ONE;
                            end
                        end
                        OCC_ONE: begin
                            if (w_in_fire && !w_out_fire) begin
                                r_state    <= OCC_FULL;
                                r_in_ready <= 1'b0;
                            end else if (w_out_fire && !w_in_fire) begin
                                r_state <= OCC_EMPTY;
                            end
                        end
                        OCC_FULL: begin
                            if (w_out_fire) begin
                                r_state    <= OCC_ONE;
                                r_in_ready <= 1'b1;
                            end
                        end
                        default: begin
                            r_state    <= OCC_EMPTY;
                            r_in_ready <= 1'b1;
                        end
                    endcase
                end
            end

            assign in_ready  = r_in_ready;
            assign occupancy = r_state;
        end else begin : g_single
            assign w_main_load  = w_in_fire;
            assign w_main_clear = w_out_fire & ~w_in_fire;
            assign w_main_data  = in_data;
            assign w_main_ctrl  = in_ctrl;
            assign in_ready     = ~out_valid | out_ready;
            assign occupancy    = {1'b0, out_valid};
        end
    endgenerate

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Directed and scoreboard bench for pipe_stage_reg (SKID=1/0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    always #5 clk = ~clk;

    logic          flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0]    occupancy;

    logic          flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [DW-1:0] in_data0, out_data0;
    logic [CW-1:0] in_ctrl0, out_ctrl0;
    logic [1:0]    occupancy0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .occupancy(occupancy)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_ctrl(in_ctrl0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .out_ctrl(out_ctrl0), .occupancy(occupancy0)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    ent_t q[$];

    initial begin
        rst = 1'b1;
        flush = 0; in_valid = 0; in_data = '0; in_ctrl = '0; out_ready = 0;
        flush0 = 0; in_valid0 = 0; in_data0 = '0; in_ctrl0 = '0; out_ready0 = 0;

        // Reset asserted before any clock edge.
        #3;
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_ctrl",  DW'(out_ctrl),  DW'(0));
        check("rst_out_data",  out_data,       DW'(0));
        check("rst_occ",       DW'(occupancy), DW'(0));
        check("rst_occ0",      DW'(occupancy0), DW'(0));
        tick();
        rst = 1'b0;
        #1;
        check("rst_in_ready",  DW'(in_ready),  DW'(1));
        check("rst_in_ready0", DW'(in_ready0), DW'(1));

        // Streaming with out_ready high.
        out_ready = 1; in_valid = 1;
        for (int k = 1; k <= 4; k++) begin
            in_data = DW'(k); in_ctrl = CW'(8'h10 + k);
            tick();
            check("stream_data",  out_data,        DW'(k));
            check("stream_ctrl",  DW'(out_ctrl),   DW'(8'h10 + k));
            check("stream_occ",   DW'(occupancy),  DW'(1));
            check("stream_ready", DW'(in_ready),   DW'(1));
        end
        in_valid = 0;
        tick();
        check("stream_end_valid", DW'(out_valid), DW'(0));
        check("stream_end_ctrl",  DW'(out_ctrl),  DW'(0));
        check("stream_end_occ",   DW'(occupancy), DW'(0));

        // Backpressure: A in main, B to skid, C held off.
        out_ready = 0; in_valid = 1;
        in_data = DW'(96'hA); in_ctrl = 8'hA1;
        tick();
        check("bp_a_occ",  DW'(occupancy), DW'(1));
        check("bp_a_data", out_data,       DW'(96'hA));
        in_data = DW'(96'hB); in_ctrl = 8'hB1;
        tick();
        check("bp_b_occ",   DW'(occupancy), DW'(2));
        check("bp_b_ready", DW'(in_ready),  DW'(0));
        check("bp_b_head",  out_data,       DW'(96'hA));
        check("bp_b_ctrl",  DW'(out_ctrl),  DW'(8'hA1));
        in_data = DW'(96'hC); in_ctrl = 8'hC1;
        tick();
        check("bp_c_occ",  DW'(occupancy), DW'(2));
        check("bp_c_head", out_data,       DW'(96'hA));
        out_ready = 1;
        tick();
        check("bp_out_b_data",  out_data,       DW'(96'hB));
        check("bp_out_b_ctrl",  DW'(out_ctrl),  DW'(8'hB1));
        check("bp_out_b_occ",   DW'(occupancy), DW'(1));
        check("bp_out_b_ready", DW'(in_ready),  DW'(1));
        tick();
        check("bp_out_c_data", out_data,       DW'(96'hC));
        check("bp_out_c_ctrl", DW'(out_ctrl),  DW'(8'hC1));
        check("bp_out_c_occ",  DW'(occupancy), DW'(1));
        in_valid = 0;
        tick();
        check("bp_drain_valid", DW'(out_valid), DW'(0));
        check("bp_drain_occ",   DW'(occupancy), DW'(0));

        // Flush with both entries full and a new offer D.
        out_ready = 0; in_valid = 1; in_ctrl = 8'hFF;
        in_data = DW'(96'hE);
        tick();
        in_data = DW'(96'hF);
        tick();
        check("fl_pre_occ", DW'(occupancy), DW'(2));
        flush = 1; in_data = DW'(96'hD);
        tick();
        check("fl_valid", DW'(out_valid), DW'(0));
        check("fl_ctrl",  DW'(out_ctrl),  DW'(0));
        check("fl_occ",   DW'(occupancy), DW'(0));
        check("fl_ready", DW'(in_ready),  DW'(1));
        flush = 0; in_valid = 0; out_ready = 1;
        tick();
        check("fl_no_d_valid", DW'(out_valid), DW'(0));

        // Flush in ONE while input and output both fire.
        in_valid = 1; out_ready = 0; in_data = DW'(96'h55); in_ctrl = 8'hFF;
        tick();
        flush = 1; out_ready = 1; in_data = DW'(96'hD);
        tick();
        check("fl1_valid", DW'(out_valid), DW'(0));
        check("fl1_occ",   DW'(occupancy), DW'(0));
        flush = 0; in_valid = 0;
        tick();
        check("fl1_no_d", DW'(out_valid), DW'(0));
        check("fl1_ctrl", DW'(out_ctrl),  DW'(0));

        // Asynchronous reset with two held entries, between edges.
        out_ready = 0; in_valid = 1; in_ctrl = 8'h77;
        in_data = DW'(1);
        tick();
        in_data = DW'(2);
        tick();
        in_valid = 0;
        check("arst_pre_occ", DW'(occupancy), DW'(2));
        #2 rst = 1'b1;
        #1;
        check("arst_valid", DW'(out_valid), DW'(0));
        check("arst_ctrl",  DW'(out_ctrl),  DW'(0));
        check("arst_occ",   DW'(occupancy), DW'(0));
        #1 rst = 1'b0;
        #1;
        check("arst_ready", DW'(in_ready), DW'(1));

        // SKID=0 stall and combinational in_ready.
        in_valid0 = 1; out_ready0 = 0; in_data0 = DW'(96'h111); in_ctrl0 = 8'h3C;
        tick();
        check("s0_valid", DW'(out_valid0),  DW'(1));
        check("s0_occ",   DW'(occupancy0),  DW'(1));
        check("s0_data",  out_data0,        DW'(96'h111));
        in_data0 = DW'(96'h222); in_ctrl0 = 8'h5A;
        #1;
        check("s0_stall_ready", DW'(in_ready0), DW'(0));
        tick();
        check("s0_stall_hold", out_data0, DW'(96'h111));
        out_ready0 = 1;
        #1;
        check("s0_go_ready", DW'(in_ready0), DW'(1));
        tick();
        check("s0_replace_data", out_data0,       DW'(96'h222));
        check("s0_replace_ctrl", DW'(out_ctrl0),  DW'(8'h5A));
        in_valid0 = 0;
        tick();
        check("s0_drain_valid", DW'(out_valid0), DW'(0));
        check("s0_drain_ctrl",  DW'(out_ctrl0),  DW'(0));
        check("s0_drain_data",  out_data0,       DW'(96'h222));
        check("s0_drain_occ",   DW'(occupancy0), DW'(0));
        in_valid0 = 1; in_data0 = DW'(96'h333); out_ready0 = 0;
        tick();
        flush0 = 1; in_data0 = DW'(96'h444);
        tick();
        check("s0_flush_valid", DW'(out_valid0), DW'(0));
        check("s0_flush_ctrl",  DW'(out_ctrl0),  DW'(0));
        flush0 = 0; in_valid0 = 0;

        // Random traffic on SKID=1 against a FIFO scoreboard.
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic m_ready, m_valid;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = DW'(cyc + 1000);
            in_ctrl   = CW'($urandom_range(1, 255));
            #1;
            m_ready = (q.size() < 2);
            m_valid = (q.size() != 0);
            check("rnd_ready", DW'(in_ready),  DW'(m_ready));
            check("rnd_valid", DW'(out_valid), DW'(m_valid));
            check("rnd_occ",   DW'(occupancy), DW'(q.size()));
            if (m_valid) begin
                check("rnd_data", out_data,      q[0].d);
                check("rnd_ctrl", DW'(out_ctrl), DW'(q[0].c));
            end else begin
                check("rnd_bubble_ctrl", DW'(out_ctrl), DW'(0));
            end
            if (flush) begin
                q.delete();
            end else begin
                if (m_valid && out_ready) void'(q.pop_front());
                if (in_valid && m_ready) q.push_back('{d: in_data, c: in_ctrl});
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
